blink_meter: RTL and testbench

BLINK_METER -- requirements
Module: blink_meter

---
 rtl/blink_meter.sv | 188 ++++++++++++++++++
 tb/tb_blink_meter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/blink_meter.sv
// -----------------------------------------------------------------------------
// blink_meter
//
// Measures a slow square wave (typically a blinker output) against i_clk.
// For every rising edge after the first, it reports the number of i_clk cycles
// since the previous rising edge (o_period). It also reports how many of those
// cycles the input was high (o_high). If no rising edge arrives within
// TIMEOUT_CYCLES, o_timeout is raised and the meter re-arms.
//
// Parameters
//   WIDTH           width of the period / high-time counters and outputs
//   TIMEOUT_CYCLES  cycles without a rising edge before timeout
//                   (must satisfy 2 <= TIMEOUT_CYCLES < 2**WIDTH)
//
// Ports
//   i_clk      in   1      system clock, all state on the rising edge
//   i_rst      in   1      asynchronous active-high reset (release must be
//                          synchronous to i_clk; not resynchronized here)
//   i_in       in   1      square wave under measurement, asynchronous
//   o_period   out  WIDTH  cycles between the last two rising edges
//   o_high     out  WIDTH  cycles i_in was high within that period
//   o_valid    out  1      one-cycle strobe, o_period/o_high updated
//   o_timeout  out  1      level, no rising edge within TIMEOUT_CYCLES
//
// Build option
//   BLINK_METER_DUTY_EN  when defined, the high-time counter is built and
//                        o_high is live. When undefined, o_high is tied to 0.
// -----------------------------------------------------------------------------
module blink_meter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 200_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_valid,
    output logic             o_timeout
);

    localparam logic [WIDTH-1:0] TIMEOUT_VAL = WIDTH'(TIMEOUT_CYCLES);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer and edge history
    // -------------------------------------------------------------------------
    logic meta_reg;   // first synchronizer stage (may be metastable)
    logic sync_reg;   // synchronized copy of i_in
    logic hist_reg;   // sync_reg delayed by one cycle, for edge detection
    logic rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            hist_reg <= 1'b0;
        end else begin
            meta_reg <= i_in;
            sync_reg <= meta_reg;
            hist_reg <= sync_reg;
        end
    end

    assign rise = sync_reg & ~hist_reg;

    // -------------------------------------------------------------------------
    // Measurement state
    // -------------------------------------------------------------------------
    state_t           state_reg,      state_next;
    logic [WIDTH-1:0] period_cnt_reg, period_cnt_next;
    logic [WIDTH-1:0] period_reg,     period_next;
    logic             valid_reg,      valid_next;
    logic             timeout_reg,    timeout_next;

`ifdef BLINK_METER_DUTY_EN
    logic [WIDTH-1:0] high_cnt_reg,   high_cnt_next;
    logic [WIDTH-1:0] high_reg,       high_next;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            period_cnt_reg <= '0;
            period_reg     <= '0;
            valid_reg      <= 1'b0;
            timeout_reg    <= 1'b0;
`ifdef BLINK_METER_DUTY_EN
            high_cnt_reg   <= '0;
            high_reg       <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            period_cnt_reg <= period_cnt_next;
            period_reg     <= period_next;
            valid_reg      <= valid_next;
            timeout_reg    <= timeout_next;
`ifdef BLINK_METER_DUTY_EN
            high_cnt_reg   <= high_cnt_next;
            high_reg       <= high_next;
`endif
        end
    end

    // Counting convention: the cycle in which the rising edge is seen counts
    // as cycle 1 of the new period. That cycle is high, so the high counter
    // also restarts at 1. With that convention, a rising edge seen while the
    // period counter reads N reports exactly N. Toggling every cycle
    // therefore reports period 2, high 1.
    always_comb begin
        state_next      = state_reg;
        period_cnt_next = period_cnt_reg;
        period_next     = period_reg;
        valid_next      = 1'b0;
        timeout_next    = timeout_reg;
`ifdef BLINK_METER_DUTY_EN
        high_cnt_next   = high_cnt_reg;
        high_next       = high_reg;
`endif

        case (state_reg)
            IDLE: begin
                // The first edge only starts a period; there is nothing to
                // report yet.
                if (rise) begin
                    state_next      = MEASURE;
                    period_cnt_next = ONE;
                    timeout_next    = 1'b0;
`ifdef BLINK_METER_DUTY_EN
                    high_cnt_next   = ONE;
`endif
                end
            end

            MEASURE: begin
                // A rising edge is checked before the timeout. A period of
                // exactly TIMEOUT_CYCLES is still a valid measurement.
                if (rise) begin
                    period_next     = period_cnt_reg;
                    valid_next      = 1'b1;
                    period_cnt_next = ONE;
`ifdef BLINK_METER_DUTY_EN
                    high_next       = high_cnt_reg;
                    high_cnt_next   = ONE;
`endif
                end else if (period_cnt_reg == TIMEOUT_VAL) begin
                    // Leave the last reported values in place. Park the
                    // counters at zero until the next first edge.
                    state_next      = IDLE;
                    timeout_next    = 1'b1;
                    period_cnt_next = '0;
`ifdef BLINK_METER_DUTY_EN
                    high_cnt_next   = '0;
`endif
                end else begin
                    // The timeout bounds period_cnt below 2**WIDTH, so the
                    // counter cannot wrap. high_cnt never exceeds period_cnt.
                    period_cnt_next = period_cnt_reg + ONE;
`ifdef BLINK_METER_DUTY_EN
                    if (sync_reg) begin
                        high_cnt_next = high_cnt_reg + ONE;
                    end
`endif
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_period  = period_reg;
    assign o_valid   = valid_reg;
    assign o_timeout = timeout_reg;

`ifdef BLINK_METER_DUTY_EN
    assign o_high = high_reg;
`else
    assign o_high = '0;
`endif

endmodule

// File: tb/tb_blink_meter.sv
// -----------------------------------------------------------------------------
// tb_blink_meter
//
// Directed test of blink_meter, built with TIMEOUT_CYCLES = 100.
//
// i_in is driven 1 time unit after a rising clock edge. The edge numbered
// cyc+1 is therefore the first to sample it. The strobe for a rising edge
// driven after edge e is registered by edge e+3. That is three register
// stages: two synchronizer flops and the output register.
//
// Period and high time are computed from the driven waveform itself: the
// distance between driven rising edges, and the number of driven-high cycles.
// -----------------------------------------------------------------------------
module tb_blink_meter;

    localparam int WIDTH = 32;
    localparam int TO    = 100;

`ifdef BLINK_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             din;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high;
    logic             valid;
    logic             timeout;

    blink_meter #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_in      (din),
        .o_period  (period),
        .o_high    (high),
        .o_valid   (valid),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected strobes
    typedef struct {
        int at;
        int per;
        int hi;
    } strobe_t;

    strobe_t exp_q[$];
    bit      armed   = 1'b0;
    int      last_rise = 0;
    int      hi_acc  = 0;
    logic    prev_in = 1'b0;
    bit      mon_en  = 1'b0;

    task automatic drive(input logic v);
        strobe_t s;
        @(posedge clk);
        #1;
        din = v;
        if (v && !prev_in) begin
            // After TO quiet cycles the meter has timed out and gone back to
            // waiting for a first edge, so this edge produces no strobe.
            if (armed && (cyc - last_rise) <= TO) begin
                s.at  = cyc + 3;
                s.per = cyc - last_rise;
                s.hi  = DUTY ? hi_acc : 0;
                exp_q.push_back(s);
            end
            armed     = 1'b1;
            last_rise = cyc;
            hi_acc    = 1;
        end else if (v) begin
            hi_acc++;
        end
        prev_in = v;
    endtask

    task automatic run_wave(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < per; i++)
                drive(i < hi);
    endtask

    // Strobe monitor, sampled on the falling edge
    logic exp_v;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].at == cyc);
            check("valid", {63'd0, valid}, {63'd0, exp_v});
            if (valid)
                $display("strobe cycle=%0d period=%0d high=%0d", cyc, period, high);
            if (exp_v) begin
                check("period", 64'(period), 64'(exp_q[0].per));
                check("high", 64'(high), 64'(exp_q[0].hi));
                void'(exp_q.pop_front());
            end
        end
    end

    int r;

    initial begin
        rst = 1'b0;
        din = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_period", 64'(period), 64'd0);
        check("rst_high", 64'(high), 64'd0);
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_timeout", {63'd0, timeout}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Period 10, high 5: first edge silent, then 10/5
        run_wave(10, 5, 4);

        // Toggle every cycle: minimum period 2, high 1
        run_wave(2, 1, 6);

        // Period change 10 -> 30 with an irregular gap between the two runs
        run_wave(10, 5, 3);
        repeat (7) drive(1'b0);
        run_wave(30, 15, 3);

        // Reset in the low phase of a running period-20 wave
        run_wave(20, 10, 2);
        repeat (10) drive(1'b1);
        repeat (3) drive(1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_period", 64'(period), 64'd0);
        check("mid_rst_high", 64'(high), 64'd0);
        check("mid_rst_valid", {63'd0, valid}, 64'd0);
        check("mid_rst_timeout", {63'd0, timeout}, 64'd0);
        exp_q.delete();
        armed = 1'b0;
        drive(1'b0);
        drive(1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_wave(20, 10, 3);

        // Let it time out. Outputs keep the last measurement.
        repeat (120) drive(1'b0);
        check("to_set", {63'd0, timeout}, 64'd1);
        check("to_hold_period", 64'(period), 64'd20);
        check("to_hold_high", 64'(high), DUTY ? 64'd10 : 64'd0);

        // A lone edge clears the timeout once it reaches the state machine,
        // and produces no strobe
        drive(1'b1);
        for (int k = 1; k <= 9; k++) begin
            drive(1'b0);
            if (k == 2) check("to_before_clear", {63'd0, timeout}, 64'd1);
            if (k == 3) check("to_cleared", {63'd0, timeout}, 64'd0);
        end
        run_wave(10, 5, 2);

        // Period exactly TO: the edge wins over the timeout
        run_wave(100, 50, 3);
        check("to_boundary", {63'd0, timeout}, 64'd0);
        r = last_rise;
        for (int k = 1; k <= 110; k++) begin
            drive(1'b0);
            if (cyc == r + 102) check("to_pre", {63'd0, timeout}, 64'd0);
            if (cyc == r + 103) check("to_fire", {63'd0, timeout}, 64'd1);
        end
        check("to_keep_period", 64'(period), 64'd100);

        repeat (8) drive(1'b0);
        check("strobes_pending", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
